sobel_cfg_ctrl: RTL and testbench

Frame-synchronous configuration controller for the Sobel edge stage. It debounces three board push-buttons and accepts host register writes, and arbitrates both into shadow registers. It applies the pending `threshold` / `change_sobel` values to the Sobel datapath only at a vertical-sync rising edge, so an output frame never mixes two configurations. It sits between the key/host interface and the Sobel block in the HDMI pixel clock domain.

---
 rtl/sobel_cfg_pkg.sv | 25 ++
 rtl/key_debounce.sv | 53 +++++
 rtl/sobel_cfg_ctrl.sv | 147 ++++++++++++++
 tb/tb_sobel_cfg_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sobel_cfg_pkg.sv
// Shared types and default constants for the Sobel configuration controller.
package sobel_cfg_pkg;

  localparam int THR_W = 21;

  localparam logic [THR_W-1:0] THR_DEFAULT_C = 21'd150;
  localparam logic [THR_W-1:0] THR_STEP_C    = 21'd10;
  localparam logic [THR_W-1:0] THR_MIN_C     = 21'd20;
  localparam logic [THR_W-1:0] THR_MAX_C     = 21'd500;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    APPLY = 2'd2
  } state_t;

  function automatic logic [THR_W-1:0] clamp_thr(input logic [THR_W-1:0] v,
                                                 input logic [THR_W-1:0] lo,
                                                 input logic [THR_W-1:0] hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, press strobe.
// press_o pulses one cycle, 2 + DEBOUNCE_CYCLES cycles after the raw key falls.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= key_n_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  // Any cycle where the synchronised level matches the accepted one restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        press_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/sobel_cfg_ctrl.sv
// Arbitrates debounced keys and host writes into shadow config, applied at vs rising edge.
// vs edge at cycle N -> APPLY at N+1 -> outputs and apply_pulse valid from edge N+2.
module sobel_cfg_ctrl
  import sobel_cfg_pkg::*;
#(
  parameter int               DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [THR_W-1:0] THR_DEFAULT     = THR_DEFAULT_C,
  parameter logic [THR_W-1:0] THR_STEP        = THR_STEP_C,
  parameter logic [THR_W-1:0] THR_MIN         = THR_MIN_C,
  parameter logic [THR_W-1:0] THR_MAX         = THR_MAX_C
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_mode_n,
  input  logic             key_up_n,
  input  logic             key_dn_n,
  input  logic             cfg_we,
  input  logic [THR_W-1:0] cfg_thr,
  input  logic             cfg_mode,
  input  logic             vs,
  output logic [THR_W-1:0] threshold,
  output logic             change_sobel,
  output logic             pending,
  output logic             apply_pulse,
  output logic [15:0]      frame_cnt
);

  logic mode_ev, up_ev, dn_ev;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
    .clk(clk), .rst_n(rst_n), .key_n_i(key_mode_n), .press_o(mode_ev));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_up (
    .clk(clk), .rst_n(rst_n), .key_n_i(key_up_n), .press_o(up_ev));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_dn (
    .clk(clk), .rst_n(rst_n), .key_n_i(key_dn_n), .press_o(dn_ev));

  state_t           state_q, state_d;
  logic             vs_q;
  logic [15:0]      frame_cnt_q;
  logic [THR_W-1:0] shd_thr_q, shd_thr_d;
  logic             shd_mode_q, shd_mode_d;
  logic [THR_W-1:0] snap_thr_q;
  logic             snap_mode_q;
  logic [THR_W-1:0] thr_q;
  logic             mode_q;
  logic             apply_pulse_q;

  logic             vs_rise;
  logic             upd;
  logic [THR_W:0]   up_sum;
  logic [THR_W:0]   dn_floor;
  logic             diff_applied;
  logic             diff_snap;
  logic             apply_en;
  logic             snap_en;

  assign vs_rise  = vs & ~vs_q;
  assign up_sum   = {1'b0, shd_thr_q} + {1'b0, THR_STEP};
  assign dn_floor = {1'b0, THR_MIN} + {1'b0, THR_STEP};

  // Host write wins outright; opposing up/down presses cancel but a mode press survives.
  always_comb begin
    shd_thr_d  = shd_thr_q;
    shd_mode_d = shd_mode_q;
    upd        = 1'b0;
    if (cfg_we) begin
      shd_thr_d  = clamp_thr(cfg_thr, THR_MIN, THR_MAX);
      shd_mode_d = cfg_mode;
      upd        = 1'b1;
    end else begin
      if (up_ev && !dn_ev) begin
        shd_thr_d = (up_sum > {1'b0, THR_MAX}) ? THR_MAX : up_sum[THR_W-1:0];
        upd       = 1'b1;
      end else if (dn_ev && !up_ev) begin
        shd_thr_d = ({1'b0, shd_thr_q} < dn_floor) ? THR_MIN : (shd_thr_q - THR_STEP);
        upd       = 1'b1;
      end
      if (mode_ev) begin
        shd_mode_d = ~shd_mode_q;
        upd        = 1'b1;
      end
    end
  end

  assign diff_applied = (shd_thr_d != thr_q) || (shd_mode_d != mode_q);
  assign diff_snap    = (shd_thr_d != snap_thr_q) || (shd_mode_d != snap_mode_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (upd && diff_applied) state_d = PEND;
      PEND: begin
        if (vs_rise)                    state_d = APPLY;
        else if (upd && !diff_applied)  state_d = IDLE;
      end
      // Anything written at or after the vs edge is judged against the value now being applied.
      APPLY:   state_d = diff_snap ? PEND : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    apply_en = (state_q == APPLY);
    snap_en  = (state_q == PEND) && vs_rise;
    pending  = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q          <= 1'b0;
      frame_cnt_q   <= '0;
      shd_thr_q     <= THR_DEFAULT;
      shd_mode_q    <= 1'b0;
      snap_thr_q    <= THR_DEFAULT;
      snap_mode_q   <= 1'b0;
      thr_q         <= THR_DEFAULT;
      mode_q        <= 1'b0;
      apply_pulse_q <= 1'b0;
    end else begin
      vs_q          <= vs;
      shd_thr_q     <= shd_thr_d;
      shd_mode_q    <= shd_mode_d;
      apply_pulse_q <= apply_en;
      if (vs_rise) frame_cnt_q <= frame_cnt_q + 16'd1;
      // Snapshot the pre-edge shadow so same-cycle updates wait for the next frame.
      if (snap_en) begin
        snap_thr_q  <= shd_thr_q;
        snap_mode_q <= shd_mode_q;
      end
      if (apply_en) begin
        thr_q  <= snap_thr_q;
        mode_q <= snap_mode_q;
      end
    end
  end

  assign threshold    = thr_q;
  assign change_sobel = mode_q;
  assign apply_pulse  = apply_pulse_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_sobel_cfg_ctrl.sv
// Directed bench for sobel_cfg_ctrl with a short debounce window.
module tb_sobel_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_mode_n, key_up_n, key_dn_n;
  logic        cfg_we;
  logic [20:0] cfg_thr;
  logic        cfg_mode;
  logic        vs;
  logic [20:0] threshold;
  logic        change_sobel, pending, apply_pulse;
  logic [15:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int apply_cnt = 0;
  int base;

  sobel_cfg_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_mode_n(key_mode_n), .key_up_n(key_up_n), .key_dn_n(key_dn_n),
    .cfg_we(cfg_we), .cfg_thr(cfg_thr), .cfg_mode(cfg_mode), .vs(vs),
    .threshold(threshold), .change_sobel(change_sobel), .pending(pending),
    .apply_pulse(apply_pulse), .frame_cnt(frame_cnt));

  always #5 clk = ~clk;

  always @(negedge clk) if (apply_pulse === 1'b1) apply_cnt++;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Host write for one cycle; shadow updates on the following edge.
  task automatic host_write(input logic [20:0] thr, input logic mode);
    cfg_we = 1'b1; cfg_thr = thr; cfg_mode = mode;
    tick(1);
    cfg_we = 1'b0;
  endtask

  // vs high one cycle; returns two edges later, when outputs reflect the apply.
  task automatic do_frame();
    vs = 1'b1;
    tick(1);
    vs = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key_mode_n = 1'b1; key_up_n = 1'b1; key_dn_n = 1'b1;
    cfg_we = 1'b0; cfg_thr = '0; cfg_mode = 1'b0; vs = 1'b0;
    tick(3);
    n_checks++; if (threshold !== 21'd150) begin n_fail++; $display("FAIL reset_thr: got %0d want 150", threshold); end
    n_checks++; if (change_sobel !== 1'b0) begin n_fail++; $display("FAIL reset_mode: got %b want 0", change_sobel); end
    n_checks++; if (pending !== 1'b0 || apply_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pend_pulse: got %b/%b want 0/0", pending, apply_pulse); end
    n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_fcnt: got %0d want 0", frame_cnt); end
    rst_n = 1'b1;
    tick(2);
    base = apply_cnt;
    for (int i = 0; i < 3; i++) begin
      do_frame();
      tick(3);
    end
    n_checks++; if (frame_cnt !== 16'd3) begin n_fail++; $display("FAIL idle_fcnt: got %0d want 3", frame_cnt); end
    n_checks++; if (apply_cnt !== base) begin n_fail++; $display("FAIL idle_no_apply: got %0d pulses want 0", apply_cnt - base); end
    n_checks++; if (threshold !== 21'd150 || pending !== 1'b0) begin n_fail++; $display("FAIL idle_state: got thr %0d pend %b want 150/0", threshold, pending); end
  endtask

  task automatic test_key_up();
    key_up_n = 1'b0; tick(10);
    key_up_n = 1'b1; tick(8);
    n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL up_pending: got %b want 1", pending); end
    n_checks++; if (threshold !== 21'd150) begin n_fail++; $display("FAIL up_hold: got %0d want 150", threshold); end
    base = apply_cnt;
    vs = 1'b1; tick(1); vs = 1'b0;
    n_checks++; if (threshold !== 21'd150) begin n_fail++; $display("FAIL up_early: got %0d want 150", threshold); end
    tick(1);
    n_checks++; if (threshold !== 21'd160) begin n_fail++; $display("FAIL up_applied: got %0d want 160", threshold); end
    n_checks++; if (apply_pulse !== 1'b1) begin n_fail++; $display("FAIL up_pulse: got %b want 1", apply_pulse); end
    tick(1);
    n_checks++; if (apply_pulse !== 1'b0 || pending !== 1'b0) begin n_fail++; $display("FAIL up_after: got pulse %b pend %b want 0/0", apply_pulse, pending); end
    tick(3);
    n_checks++; if (apply_cnt !== base + 1) begin n_fail++; $display("FAIL up_pulse_count: got %0d want 1", apply_cnt - base); end
  endtask

  task automatic test_host_clamp();
    host_write(21'd5, 1'b0);
    n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL host_lo_pending: got %b want 1", pending); end
    do_frame(); tick(2);
    n_checks++; if (threshold !== 21'd20) begin n_fail++; $display("FAIL host_clamp_lo: got %0d want 20", threshold); end
    host_write(21'd1000, 1'b1);
    do_frame(); tick(2);
    n_checks++; if (threshold !== 21'd500 || change_sobel !== 1'b1) begin n_fail++; $display("FAIL host_clamp_hi: got %0d/%b want 500/1", threshold, change_sobel); end
    key_up_n = 1'b0; tick(10);
    key_up_n = 1'b1; tick(8);
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL up_saturate_pend: got %b want 0", pending); end
    do_frame(); tick(2);
    n_checks++; if (threshold !== 21'd500) begin n_fail++; $display("FAIL up_saturate: got %0d want 500", threshold); end
  endtask

  task automatic test_glitch_down();
    for (int i = 0; i < 4; i++) begin
      key_dn_n = 1'b0; tick(2);
      key_dn_n = 1'b1; tick(2);
    end
    tick(6);
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL glitch_pending: got %b want 0", pending); end
    host_write(21'd25, 1'b1);
    key_dn_n = 1'b0; tick(10);
    key_dn_n = 1'b1; tick(8);
    do_frame(); tick(2);
    n_checks++; if (threshold !== 21'd20) begin n_fail++; $display("FAIL down_floor: got %0d want 20", threshold); end
  endtask

  task automatic test_host_vs_key();
    // Press event is asserted during the 7th cycle after the key falls.
    key_up_n = 1'b0; tick(6);
    cfg_we = 1'b1; cfg_thr = 21'd300; cfg_mode = 1'b1;
    tick(1);
    cfg_we = 1'b0;
    tick(3);
    key_up_n = 1'b1; tick(8);
    do_frame(); tick(2);
    n_checks++; if (threshold !== 21'd300) begin n_fail++; $display("FAIL host_over_key: got %0d want 300", threshold); end
  endtask

  task automatic test_back_to_back();
    host_write(21'd350, 1'b1);
    cfg_we = 1'b1; cfg_thr = 21'd400; cfg_mode = 1'b1; vs = 1'b1;
    tick(1);
    cfg_we = 1'b0; vs = 1'b0;
    tick(1);
    n_checks++; if (threshold !== 21'd350) begin n_fail++; $display("FAIL vs_same_cycle_thr: got %0d want 350", threshold); end
    n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL vs_same_cycle_pend: got %b want 1", pending); end
    tick(3);
    do_frame(); tick(2);
    n_checks++; if (threshold !== 21'd400 || pending !== 1'b0) begin n_fail++; $display("FAIL next_frame_apply: got %0d pend %b want 400/0", threshold, pending); end
  endtask

  task automatic test_reset_mid_pend();
    host_write(21'd200, 1'b0);
    n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL midpend_setup: got %b want 1", pending); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (threshold !== 21'd150 || change_sobel !== 1'b0) begin n_fail++; $display("FAIL midpend_reset_out: got %0d/%b want 150/0", threshold, change_sobel); end
    n_checks++; if (pending !== 1'b0 || frame_cnt !== 16'd0) begin n_fail++; $display("FAIL midpend_reset_state: got pend %b fcnt %0d want 0/0", pending, frame_cnt); end
    tick(2);
    rst_n = 1'b1;
    tick(2);
    base = apply_cnt;
    do_frame(); tick(2);
    n_checks++; if (threshold !== 21'd150 || apply_cnt !== base) begin n_fail++; $display("FAIL post_reset_frame: got %0d pulses %0d want 150/0", threshold, apply_cnt - base); end
  endtask

  initial begin
    test_reset();
    test_key_up();
    test_host_clamp();
    test_glitch_down();
    test_host_vs_key();
    test_back_to_back();
    test_reset_mid_pend();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
